vga_scan_timing: RTL

- Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock.
- Directly upstream of the checkerboard/piece renderer: supplies the pixel coordinate pair x[9:0], y[8:0] that the renderer converts to r/g/b.
- Also supplies the sync and blanking strobes, plus a per-frame pulse the game logic uses to update the board buffer during vertical blank.

---
 rtl/vga_scan_timing.sv | 116 +++++++++++
 1 files changed

// File: rtl/vga_scan_timing.sv
// ---------------------------------------------------------------------------
// vga_scan_timing
//
// 640x480@60 Hz VGA raster generator running from the 50 MHz system clock.
// A clock divider produces a one-clk pixel strobe; horizontal and vertical
// counters advance on that strobe, and every video output is a registered
// decode of the counters' next values. The outputs therefore always describe
// the current counter position. There is no input-to-output combinational
// path.
//
// Ports:
//   clk         system clock (50 MHz)
//   reset       synchronous, active-high reset
//   pix_tick    one-clk pulse; counters advance on the edge that ends it
//   x[9:0]      visible pixel column (0 outside the active region)
//   y[8:0]      visible pixel row (0 outside the active region)
//   blank_n     1 inside the active video region
//   hsync_n     horizontal sync, active low
//   vsync_n     vertical sync, active low (asserted across whole lines)
//   frame_done  one-clk pulse when the raster wraps from the last pixel of
//               the last line back to (0,0)
// ---------------------------------------------------------------------------
module vga_scan_timing #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       blank_n,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_done
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [3:0] div_cnt;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [9:0] hcount_nxt;
    logic [9:0] vcount_nxt;
    logic       h_wrap;
    logic       v_wrap;

    // Next raster position. Outputs are decoded from these values so they
    // change on the same edge as the counters themselves.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        hcount_nxt = hcount;
        vcount_nxt = vcount;
        h_wrap     = (hcount == H_LAST);
        v_wrap     = (vcount == V_LAST);
        if (pix_tick) begin
            if (h_wrap) begin
                hcount_nxt = '0;
                vcount_nxt = v_wrap ? '0 : vcount + 10'd1;
            end else begin
                hcount_nxt = hcount + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            div_cnt    <= '0;
            pix_tick   <= 1'b0;
            hcount     <= '0;
            vcount     <= '0;
            x          <= '0;
            y          <= '0;
            blank_n    <= 1'b1;
            hsync_n    <= 1'b1;
            vsync_n    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            div_cnt  <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
            pix_tick <= (div_cnt == DIV_LAST);
            hcount   <= hcount_nxt;
            vcount   <= vcount_nxt;

            blank_n  <= (hcount_nxt < H_VIS) && (vcount_nxt < V_VIS);
            x        <= (hcount_nxt < H_VIS) ? hcount_nxt : 10'd0;
            y        <= (vcount_nxt < V_VIS) ? vcount_nxt[8:0] : 9'd0;
            hsync_n  <= !((hcount_nxt >= HS_START) && (hcount_nxt < HS_END));
            vsync_n  <= !((vcount_nxt >= VS_START) && (vcount_nxt < VS_END));

            // Only the tick that wraps the last pixel of the last line.
            frame_done <= pix_tick && h_wrap && v_wrap;
        end
    end

endmodule
